// File: rtl/serial_key_matrix.sv
// serial_key_matrix
//   Turns ASCII bytes from the serial keyboard UART into timed key presses on the
//   virtual Galaksija key matrix that the CPU scans. Incoming bytes go into a small
//   type-ahead FIFO. Each byte is translated to a matrix index and an optional SHIFT.
//   The key is held for HOLD_CYCLES. All keys are then released for GAP_CYCLES
//   before the next byte is taken.
//
// Ports
//   clk        system clock (CPU clock domain)
//   resetn     asynchronous active-low reset
//   rx_data    byte from uart_rx
//   rx_valid   1-cycle strobe, rx_data valid
//   flush      1-cycle strobe, discards FIFO/FSM state and clears overflow
//   rd         CPU read of the keyboard region
//   key_addr   key index being read
//   key_out    registered read data: 8'hFE pressed, 8'hFF released
//   busy       a press/gap is in progress or bytes are waiting
//   overflow   sticky: a byte was dropped because the FIFO was full
module serial_key_matrix #(
  parameter int NUM_KEYS    = 64,
  parameter int ADDR_W      = 6,
  parameter int DEPTH_LOG2  = 4,
  parameter int HOLD_CYCLES = 1000000,
  parameter int GAP_CYCLES  = 500000,
  parameter int CNT_W       = 24,
  parameter int SHIFT_KEY   = 53
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              flush,
  input  logic              rd,
  input  logic [ADDR_W-1:0] key_addr,
  output logic [7:0]        key_out,
  output logic              busy,
  output logic              overflow
);

  localparam int DEPTH    = 2 ** DEPTH_LOG2;
  localparam int NUM_ADDR = 2 ** ADDR_W;

  typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_GAP} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    timer_reg, timer_next;
  logic [ADDR_W-1:0]   key_reg, key_next;
  logic                shift_reg, shift_next;

  logic [7:0]            fifo_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic                  overflow_reg;
  logic [7:0]            key_out_reg;

  logic       fifo_empty, fifo_full, push, pop;
  logic [8:0] xlate;  // {mapped, shift, index[6:0]}

  // ASCII -> {mapped, shift, matrix index}. Unmapped bytes return all zeros.
  function automatic logic [8:0] translate(input logic [7:0] c);
    logic [8:0] r;
    r = '0;
    case (c) inside
      [8'h41:8'h5A]: r = {2'b10, c[6:0] - 7'd64};  // 'A'-'Z' -> 1..26
      [8'h61:8'h7A]: r = {2'b10, c[6:0] - 7'd96};  // 'a'-'z' -> 1..26
      [8'h30:8'h39]: r = {2'b10, c[6:0] - 7'd16};  // '0'-'9' -> 32..41
      8'h0D, 8'h0A:  r = {2'b10, 7'd48};           // CR / LF
      8'h08, 8'h7F:  r = {2'b10, 7'd29};           // BS / DEL
      8'h1B:         r = {2'b10, 7'd49};           // ESC
      8'h20:         r = {2'b10, 7'd31};           // space
      // symbols that need SHIFT on the Galaksija keyboard
      8'h5F:         r = {2'b11, 7'd32};           // _
      8'h21:         r = {2'b11, 7'd33};           // !
      8'h22:         r = {2'b11, 7'd34};           // "
      8'h23:         r = {2'b11, 7'd35};           // #
      8'h24:         r = {2'b11, 7'd36};           // $
      8'h25:         r = {2'b11, 7'd37};           // %
      8'h26:         r = {2'b11, 7'd38};           // &
      8'h5C:         r = {2'b11, 7'd39};           // backslash
      8'h28:         r = {2'b11, 7'd40};           // (
      8'h29:         r = {2'b11, 7'd41};           // )
      8'h2B:         r = {2'b11, 7'd42};           // +
      8'h2A:         r = {2'b11, 7'd43};           // *
      8'h3C:         r = {2'b11, 7'd44};           // <
      8'h2D:         r = {2'b11, 7'd45};           // -
      8'h3E:         r = {2'b11, 7'd46};           // >
      8'h3F:         r = {2'b11, 7'd47};           // ?
      // unshifted symbols sharing those keys
      8'h3B:         r = {2'b10, 7'd42};           // ;
      8'h3A:         r = {2'b10, 7'd43};           // :
      8'h2C:         r = {2'b10, 7'd44};           // ,
      8'h3D:         r = {2'b10, 7'd45};           // =
      8'h2E:         r = {2'b10, 7'd46};           // .
      8'h2F:         r = {2'b10, 7'd47};           // /
      default:       r = '0;
    endcase
    return r;
  endfunction

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == (DEPTH_LOG2 + 1)'(DEPTH));

  // The FIFO read is asynchronous. This lets IDLE pop and translate a byte in
  // the same cycle, so a discarded byte costs exactly one cycle.
  assign pop  = (state_reg == ST_IDLE) && !fifo_empty && !flush;
  // When the FIFO is full, a pop in the same cycle frees a slot for the incoming byte.
  assign push = rx_valid && !flush && (!fifo_full || pop);

  assign xlate = translate(fifo_mem[rd_ptr_reg]);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (rx_valid && !push) overflow_reg <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      timer_reg <= '0;
      key_reg   <= '0;
      shift_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      key_reg   <= key_next;
      shift_reg <= shift_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    key_next   = key_reg;
    shift_next = shift_reg;
    if (flush) begin
      // Release immediately. No gap is inserted after a flushed press.
      state_next = ST_IDLE;
      timer_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pop && xlate[8] && (int'(xlate[6:0]) < NUM_KEYS)) begin
            key_next   = ADDR_W'(xlate[6:0]);
            shift_next = xlate[7];
            timer_next = CNT_W'(HOLD_CYCLES - 1);
            state_next = ST_PRESS;
          end
        end
        ST_PRESS: begin
          if (timer_reg == '0) begin
            timer_next = CNT_W'(GAP_CYCLES - 1);
            state_next = ST_GAP;
          end else begin
            timer_next = timer_reg - 1'b1;
          end
        end
        ST_GAP: begin
          if (timer_reg == '0) begin
            state_next = ST_IDLE;
          end else begin
            timer_next = timer_reg - 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // One decode per matrix address. SHIFT is added on top of the latched key for
  // shifted symbols.
  logic [NUM_ADDR-1:0] pressed_vec;
  for (genvar gi = 0; gi < NUM_ADDR; gi++) begin : g_key
    assign pressed_vec[gi] = (state_reg == ST_PRESS) &&
                             ((key_reg == ADDR_W'(gi)) || (shift_reg && (gi == SHIFT_KEY)));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_out_reg <= 8'hFF;
    end else if (rd) begin
      key_out_reg <= pressed_vec[key_addr] ? 8'hFE : 8'hFF;
    end
  end

  assign key_out  = key_out_reg;
  assign busy     = (state_reg != ST_IDLE) || !fifo_empty;
  assign overflow = overflow_reg;

endmodule
